xor_stream_accum: RTL
=====================

XOR_STREAM_ACCUM -- requirements
Module: xor_stream_accum

Interface
REQ-001 SHALL have parameter WIDTH, default 8, bits per lane word (legal 1..64).
REQ-002 SHALL have parameter LANES, default 2, lane words per input beat (legal 1..8).
REQ-003 SHALL have port clk  input  1  the single clock; all state updates on the rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-005 SHALL have port in_valid  input  1  input beat present.
REQ-006 SHALL have port in_ready  output  1  block accepts the input beat.
REQ-007 SHALL have port in_data  input  LANES*WIDTH  lane k occupies bits [k*WIDTH +: WIDTH].
REQ-008 SHALL have port in_last  input  1  beat is the final beat of its frame.
REQ-009 SHALL have port out_valid  output  1  frame result held.
REQ-010 SHALL have port out_ready  input  1  consumer takes the result.
REQ-011 SHALL have port out_data  output  WIDTH  XOR checksum of the frame.
REQ-012 SHALL have port out_beats  output  8  accepted beats in the frame, saturating at 255.

Function
REQ-013 SHALL treat an input beat as accepted on a rising edge where in_valid=1 and in_ready=1.
REQ-014 SHALL treat the output as transferred on a rising edge where out_valid=1 and out_ready=1.
REQ-015 SHALL have exactly two states: ACCUM, where in_ready=1 and out_valid=0, and HOLD, where in_ready=0 and out_valid=1.
REQ-016 SHALL compute the beat value as the bitwise XOR of all LANES lane words; with LANES=1 the beat value SHALL equal in_data.
REQ-017 SHALL, on an accepted non-last beat, set acc to acc XOR beat value, add 1 to the beat count (holding at 255 once reached), and stay in ACCUM.
REQ-018 SHALL, on an accepted last beat, load out_data with acc XOR beat value, load out_beats with the count including this beat (saturated), clear acc and count, and move to HOLD.
REQ-019 SHALL assert out_valid in the cycle after the last beat is accepted (one-cycle latency).
REQ-020 SHALL hold out_data and out_beats stable while in HOLD until the output transfers.
REQ-021 SHALL return to ACCUM on an output transfer, so that in_ready=1 in the following cycle.
REQ-022 SHALL give a single-beat frame (in_last=1 on the first beat) out_beats=1.
REQ-023 SHALL ignore in_data and in_last whenever in_valid=0 or in_ready=0.
REQ-024 SHALL have no combinational path from in_valid or out_ready to any output.

Reset
REQ-025 SHALL, while rst_n=0 and independently of clk, force state=ACCUM, acc=0, count=0, out_data=0, out_beats=0, out_valid=0 and in_ready=1.
REQ-026 SHALL discard any partial frame or held result on reset; the next accepted beat after reset SHALL start a new frame.

Configuration
REQ-027 SHALL, when the macro XOR_STREAM_PARITY_EN is defined, add port out_parity  output  1, equal to the XOR reduction of out_data, registered with out_data and reset to 0.
REQ-028 SHALL, when XOR_STREAM_PARITY_EN is undefined, omit the out_parity port, with all other behaviour unchanged.

Verification
REQ-029 SHALL cover: WIDTH=8, LANES=2, beats {0x12,0x34},{0xFF,0x0F} with last on beat 2 -> out_data=0xD6, out_beats=2, out_valid high one cycle after beat 2.
REQ-030 SHALL cover: single beat {0xA5,0x5A}, in_last=1 -> out_data=0xFF, out_beats=1; with XOR_STREAM_PARITY_EN defined, out_parity=0.
REQ-031 SHALL cover: result held with out_ready=0 for 5 cycles while in_valid=1 -> in_ready=0, out_data unchanged, no beat consumed; after out_ready=1 the pending beat is accepted the next cycle.
REQ-032 SHALL cover: 300-beat frame of {0x01,0x00} -> out_beats=255, out_data=0x00 (even beat count).
REQ-033 SHALL cover: rst_n pulsed low mid-frame after 3 beats -> outputs at reset values at once; next frame {0x0F,0x00} last -> out_data=0x0F, out_beats=1.
REQ-034 SHALL cover: LANES=1, WIDTH=16, beats 0x1234 then 0x1234 last -> out_data=0x0000, out_beats=2.

Source files
------------

// File: rtl/xor_stream_accum.sv
// Frame XOR checksum accumulator: folds lane words of each accepted beat into a
// running checksum and holds the frame result until taken. Optional out_parity via XOR_STREAM_PARITY_EN.
module xor_stream_accum #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned LANES = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [LANES*WIDTH-1:0] in_data,
  input  logic                   in_last,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [WIDTH-1:0]       out_data,
  output logic [7:0]             out_beats
`ifdef XOR_STREAM_PARITY_EN
  ,
  output logic                   out_parity
`endif
);

  typedef enum logic {
    ACCUM = 1'b0,
    HOLD  = 1'b1
  } state_t;

  state_t           state;
  state_t           state_next;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] beat;
  logic [WIDTH-1:0] frame_sum;
  logic [7:0]       count;
  logic [7:0]       count_inc;
  logic             accept;

  always_comb begin
    beat = '0;
    for (int unsigned k = 0; k < LANES; k++) begin
      beat = beat ^ in_data[k*WIDTH +: WIDTH];
    end
  end

  assign frame_sum = acc ^ beat;
  assign count_inc = (count == 8'hFF) ? count : count + 8'd1;
  assign accept    = in_valid && (state == ACCUM);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ACCUM;
    end else begin
      state <= state_next;
    end
  end

  // Handshake outputs are pure state decodes, so no input reaches them combinationally.
  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    case (state)
      ACCUM: begin
        in_ready = 1'b1;
        if (in_valid && in_last) begin
          state_next = HOLD;
        end
      end
      HOLD: begin
        out_valid = 1'b1;
        if (out_ready) begin
          state_next = ACCUM;
        end
      end
      default: state_next = ACCUM;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc       <= '0;
      count     <= '0;
      out_data  <= '0;
      out_beats <= '0;
    end else if (accept) begin
      if (in_last) begin
        out_data  <= frame_sum;
        out_beats <= count_inc;
        acc       <= '0;
        count     <= '0;
      end else begin
        acc   <= frame_sum;
        count <= count_inc;
      end
    end
  end

`ifdef XOR_STREAM_PARITY_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_parity <= 1'b0;
    end else if (accept && in_last) begin
      out_parity <= ^frame_sum;
    end
  end
`endif

endmodule
